// File: rtl/door_lock_actuator.sv
// Bolt actuator: turns the lock/unlock level command into timed motor pulses, confirms each
// move on a debounced latch sensor, retries unconfirmed moves and latches a fault.
//
// state   | meaning
// S_IDLE  | bolt matches target, motors off, waiting for a new target
// S_DRIVE | motor driven toward r_dir for PULSE_CYCLES
// S_WAIT  | motors off, waiting TIMEOUT_CYCLES for latch confirmation
// S_DEAD  | motors-off gap before a retry pulse or after an abort
// S_FAULT | all attempts failed, motors off until fault clear
module door_lock_actuator #(
    parameter int PULSE_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int MAX_RETRIES    = 2,
    parameter int DEAD_CYCLES    = 8,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lock_door,
    input  logic i_latch_sensor,
    input  logic i_fault_clr,
    output logic o_motor_lock,
    output logic o_motor_unlock,
    output logic o_door_locked,
    output logic o_busy,
    output logic o_fault
);

    localparam int MAX_TA = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_T  = (MAX_TA > DEAD_CYCLES) ? MAX_TA : DEAD_CYCLES;
    localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int SW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_DEAD,
        S_FAULT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [RW-1:0] r_retries, w_retries_nxt;
    logic          r_dir, w_dir_nxt;
    logic          r_abort, w_abort_nxt;
    logic          r_sync1, r_sync2, r_latch, r_cmd;
    logic [SW-1:0] r_settle;
    logic          r_motor_lock, r_motor_unlock;

    // latch state only follows the synced sensor after SETTLE_CYCLES consecutive differing samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_latch  <= 1'b0;
            r_settle <= '0;
            r_cmd    <= 1'b0;
        end else begin
            r_sync1 <= i_latch_sensor;
            r_sync2 <= r_sync1;
            r_cmd   <= i_lock_door;
            if (r_sync2 == r_latch) begin
                r_settle <= '0;
            end else if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                r_latch  <= r_sync2;
                r_settle <= '0;
            end else begin
                r_settle <= r_settle + SW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_retries      <= '0;
            r_dir          <= 1'b0;
            r_abort        <= 1'b0;
            r_motor_lock   <= 1'b0;
            r_motor_unlock <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timer        <= w_timer_nxt;
            r_retries      <= w_retries_nxt;
            r_dir          <= w_dir_nxt;
            r_abort        <= w_abort_nxt;
            r_motor_lock   <= (r_state == S_DRIVE) && r_dir;
            r_motor_unlock <= (r_state == S_DRIVE) && !r_dir;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + TW'(1);
        w_retries_nxt = r_retries;
        w_dir_nxt     = r_dir;
        w_abort_nxt   = r_abort;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (r_cmd != r_latch) begin
                    w_dir_nxt     = r_cmd;
                    w_retries_nxt = '0;
                    w_abort_nxt   = 1'b0;
                    w_state_nxt   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cmd != r_dir) begin
                    w_abort_nxt = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_DEAD;
                end else if (r_timer == TW'(PULSE_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // confirmation wins over both abort and timeout in the same cycle
                if (r_latch == r_dir) begin
                    w_retries_nxt = '0;
                    w_timer_nxt   = '0;
                    w_state_nxt   = S_IDLE;
                end else if (r_cmd != r_dir) begin
                    w_abort_nxt = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_DEAD;
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    if (r_retries < RW'(MAX_RETRIES)) begin
                        w_retries_nxt = r_retries + RW'(1);
                        w_abort_nxt   = 1'b0;
                        w_state_nxt   = S_DEAD;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end
            S_DEAD: begin
                if (r_timer == TW'(DEAD_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    w_abort_nxt = 1'b0;
                    w_state_nxt = r_abort ? S_IDLE : S_DRIVE;
                end
            end
            S_FAULT: begin
                w_timer_nxt = '0;
                if (i_fault_clr) begin
                    w_retries_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_motor_lock   = r_motor_lock;
    assign o_motor_unlock = r_motor_unlock;
    assign o_door_locked  = r_latch;
    assign o_busy         = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_DEAD);
    assign o_fault        = (r_state == S_FAULT);

endmodule

// File: tb/tb_door_lock_actuator.sv
// Bench for door_lock_actuator: directed and randomized moves, aborts, faults and resets,
// compared sample by sample against a timeline model of the expected outputs.
module tb_door_lock_actuator;

    localparam int PULSE   = 50;
    localparam int TIMEOUT = 200;
    localparam int MAXR    = 2;
    localparam int DEAD    = 8;
    localparam int PER     = PULSE + TIMEOUT + DEAD;
    localparam int P0      = 3;     // first motor sample after the command/clear edge

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic lock_door = 1'b0;
    logic latch_sensor = 1'b0;
    logic fault_clr = 1'b0;
    logic o_motor_lock, o_motor_unlock, o_door_locked, o_busy, o_fault;

    int n_total = 0;
    int n_bad   = 0;

    // timeline model parameters for the scenario in progress
    int   m_mode;
    int   m_npulse;
    int   m_t;
    int   m_p;
    int   m_busy_end;
    logic m_dir;
    logic m_L;
    logic m_resp;
    logic cur_L = 1'b0;

    door_lock_actuator dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_lock_door    (lock_door),
        .i_latch_sensor (latch_sensor),
        .i_fault_clr    (fault_clr),
        .o_motor_lock   (o_motor_lock),
        .o_motor_unlock (o_motor_unlock),
        .o_door_locked  (o_door_locked),
        .o_busy         (o_busy),
        .o_fault        (o_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b (mlock,munlock,busy,fault,locked)", tag, got[4:0], exp[4:0]);
        end
    endtask

    function automatic logic [7:0] obs();
        return {3'b000, o_motor_lock, o_motor_unlock, o_busy, o_fault, o_door_locked};
    endfunction

    // expected outputs at sample e (negedge after the e-th posedge since the trigger)
    function automatic logic [7:0] exp_at(input int e);
        logic mot, busy, flt, dl;
        int   last;
        mot = 1'b0;
        if (m_mode == 0) begin
            for (int i = 0; i < m_npulse; i++)
                if (e >= P0 + PER * i && e <= P0 + PER * i + PULSE - 1) mot = 1'b1;
        end else begin
            last = (m_p + 5 < P0 + PULSE - 1) ? m_p + 5 : P0 + PULSE - 1;
            mot  = (e >= P0) && (e <= last);
        end
        busy = (e >= P0 - 1) && (e < m_busy_end);
        flt  = (m_mode == 0) && !m_resp && (e >= m_busy_end);
        dl   = (m_mode == 0 && m_resp && e >= m_t + 6) ? m_dir : m_L;
        return {3'b000, mot && m_dir, mot && !m_dir, busy, flt, dl};
    endfunction

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, obs(), {7'b0, cur_L});
        end
    endtask

    // a = attempt index on which the sensor follows (MAXR+1 = never), d = delay after pulse end
    task automatic run_move(input bit use_clr, input logic target, input int a, input int d,
                            input string tag);
        bit quiet;
        int b0;
        m_mode   = 0;
        m_dir    = target;
        m_L      = cur_L;
        m_resp   = (a <= MAXR);
        m_npulse = m_resp ? a + 1 : MAXR + 1;
        m_t      = P0 + PER * a + PULSE - 1 + d;
        m_busy_end = m_resp ? m_t + 7 : P0 + PER * MAXR + PULSE - 1 + TIMEOUT;
        @(negedge clk);
        if (use_clr) fault_clr = 1'b1;
        else lock_door = target;
        quiet = 1'b0;
        b0 = n_bad;
        for (int e = 1; e <= m_busy_end + 4; e++) begin
            @(negedge clk);
            if (!quiet) begin
                check($sformatf("%s@%0d", tag, e), obs(), exp_at(e));
                if (n_bad != b0) quiet = 1'b1;
            end
            if (e == 1) fault_clr = 1'b0;
            if (m_resp && e == m_t) latch_sensor = target;
        end
        if (m_resp) cur_L = target;
    endtask

    task automatic run_abort(input int p, input string tag);
        bit quiet;
        int b0;
        m_mode = 1;
        m_p    = p;
        m_L    = cur_L;
        m_dir  = !cur_L;
        m_resp = 1'b0;
        m_busy_end = 5 + p + DEAD;
        @(negedge clk);
        lock_door = !cur_L;
        quiet = 1'b0;
        b0 = n_bad;
        for (int e = 1; e <= m_busy_end + 4; e++) begin
            @(negedge clk);
            if (!quiet) begin
                check($sformatf("%s@%0d", tag, e), obs(), exp_at(e));
                if (n_bad != b0) quiet = 1'b1;
            end
            if (e == P0 + p) lock_door = cur_L;
        end
    endtask

    task automatic recover(input string tag);
        @(negedge clk);
        lock_door = cur_L;
        repeat (2) @(negedge clk);
        check({tag, "_still"}, obs(), {6'b0, 1'b1, cur_L});
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check({tag, "_clr"}, obs(), {7'b0, cur_L});
        idle_check(5, {tag, "_idle"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, a, d, p;
        #2 rst_n = 1'b0;
        #2 check("reset_async", obs(), 8'd0);
        repeat (3) @(negedge clk);
        check("reset_hold", obs(), 8'd0);
        rst_n = 1'b1;

        idle_check(500, "t6_idle");
        run_move(1'b0, 1'b1, 0, 10, "t1_lock");
        idle_check(5, "t1_after");

        for (int k = 0; k < 20; k++) begin
            latch_sensor = (k % 2 == 0) ? !cur_L : cur_L;
            repeat (2) begin
                @(negedge clk);
                check("t4_bounce", obs(), {7'b0, cur_L});
            end
        end
        idle_check(8, "t4_after");

        @(negedge clk);
        lock_door = !cur_L;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t5_async", obs(), 8'd0);
        lock_door = 1'b0;
        latch_sensor = 1'b0;
        cur_L = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_hold", obs(), 8'd0);
        rst_n = 1'b1;
        idle_check(10, "t5_idle");

        run_abort(20, "t3_abort");
        idle_check(5, "t3_after");

        run_move(1'b0, 1'b1, MAXR + 1, 0, "t2_fault");
        run_move(1'b1, 1'b1, $urandom_range(0, MAXR), $urandom_range(0, 150), "t2_fresh");
        idle_check(5, "t2_after");

        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, MAXR + 1);
            d    = $urandom_range(0, 150);
            p    = $urandom_range(0, 150);
            if (kind == 2) begin
                run_abort(p, $sformatf("rnd%0d_abort", it));
            end else begin
                run_move(1'b0, !cur_L, a, d, $sformatf("rnd%0d_move", it));
                if (a > MAXR) recover($sformatf("rnd%0d_rec", it));
            end
            idle_check(5, $sformatf("rnd%0d_idle", it));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
